// File: rtl/jam_pkg.sv
// Shared constants and types for the JAM cost server.
package jam_pkg;

  localparam int IDX_W      = 3;            // worker / job index width
  localparam int ADDR_W     = 2 * IDX_W;    // flat matrix address {row, col}
  localparam int ENTRIES    = 64;           // 8 x 8 cost matrix
  localparam int MINCOST_W  = 10;
  localparam int MATCH_W    = 4;
  localparam int DEF_COST_W = 7;            // default cost entry width

  typedef enum logic [1:0] {
    LOAD,
    ARM,
    RUN,
    REPORT
  } state_t;

endpackage

// File: rtl/jam_cost_ram.sv
// 64-entry cost matrix: one write port, one registered read port,
// asynchronously cleared to zero.
module jam_cost_ram
  import jam_pkg::*;
#(
  parameter int COST_W = DEF_COST_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [COST_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [COST_W-1:0] rdata
);

  logic [COST_W-1:0] mem [ENTRIES];

  // Matrix storage: write one entry per accepted beat.
  // NOTE: the array is reset because RST must leave every entry at zero;
  // that rules out a RAM macro and maps the matrix onto flops.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read: data for raddr appears one cycle later.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/jam_cost_server.sv
// Feeds an 8x8 cost matrix to the JAM solver, holds JAM in reset while the
// matrix loads, serves W/J lookups and reports MinCost/MatchCount.
// Optional: define JAM_COST_CHECKSUM_EN to add out_checksum, the sum of the
// 64 beats of the most recent load.
module jam_cost_server
  import jam_pkg::*;
#(
  parameter int COST_W   = DEF_COST_W,
  parameter int RUNCNT_W = 20
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [COST_W-1:0]    in_data,
  output logic                 jam_rst,
  input  logic [IDX_W-1:0]     W,
  input  logic [IDX_W-1:0]     J,
  output logic [COST_W-1:0]    Cost,
  input  logic [MINCOST_W-1:0] jam_mincost,
  input  logic [MATCH_W-1:0]   jam_matchcount,
  input  logic                 jam_valid,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MINCOST_W-1:0] out_mincost,
  output logic [MATCH_W-1:0]   out_matchcount,
`ifdef JAM_COST_CHECKSUM_EN
  output logic [COST_W+5:0]    out_checksum,
`endif
  output logic [RUNCNT_W-1:0]  out_cycles
);

  state_t              state, next_state;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [RUNCNT_W-1:0] run_cnt;
  logic                accept;
  logic                last_beat;

  assign accept    = in_valid && in_ready;
  assign last_beat = (wr_ptr == ADDR_W'(ENTRIES - 1));

  // State register; jam_rst is registered so it drops exactly on entry to RUN.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= LOAD;
      jam_rst <= 1'b1;
    end else begin
      state   <= next_state;
      jam_rst <= (next_state != RUN);
    end
  end

  // Next-state decode.
  // NOTE: next_state takes a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      LOAD:    if (accept && last_beat) next_state = ARM;
      ARM:     next_state = RUN;
      RUN:     if (jam_valid) next_state = REPORT;
      REPORT:  if (out_ready) next_state = LOAD;
      default: next_state = LOAD;
    endcase
  end

  // Handshake outputs depend on state only.
  always_comb begin
    in_ready  = (state == LOAD);
    out_valid = (state == REPORT);
  end

  // Write pointer: advances per accepted beat, wraps to 0 after the 64th.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                wr_ptr <= '0;
    else if (accept)                        wr_ptr <= wr_ptr + 1'b1;
    else if (state == REPORT && out_ready)  wr_ptr <= '0;
  end

  // Run counter: cleared in ARM, saturating count while JAM runs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                run_cnt <= '0;
    else if (state == ARM)                  run_cnt <= '0;
    else if (state == RUN && run_cnt != '1) run_cnt <= run_cnt + 1'b1;
  end

  // Result capture on the first Valid seen in RUN; held until the next one.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_mincost    <= '0;
      out_matchcount <= '0;
      out_cycles     <= '0;
    end else if (state == RUN && jam_valid) begin
      out_mincost    <= jam_mincost;
      out_matchcount <= jam_matchcount;
      out_cycles     <= run_cnt;
    end
  end

`ifdef JAM_COST_CHECKSUM_EN
  // Running sum of accepted beats, restarted by the first beat of each load.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                     out_checksum <= '0;
    else if (accept && wr_ptr == '0)
      out_checksum <= (COST_W+6)'(in_data);
    else if (accept)
      out_checksum <= out_checksum + (COST_W+6)'(in_data);
  end
`endif

  jam_cost_ram #(.COST_W(COST_W)) u_ram (
    .CLK   (CLK),
    .RST   (RST),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr ({W, J}),
    .rdata (Cost)
  );

endmodule

// File: tb/tb_jam_cost_server.sv
// Self-checking bench for jam_cost_server. The bench plays the JAM solver:
// it drives W/J lookups and the Valid/MinCost/MatchCount result. Results are
// checked by a scoreboard queue popped on each out_valid/out_ready handshake.
module tb_jam_cost_server;
  import jam_pkg::*;

  localparam int COST_W   = 7;
  localparam int RUNCNT_W = 20;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic                 in_valid;
  logic                 in_ready;
  logic [COST_W-1:0]    in_data;
  logic                 jam_rst;
  logic [IDX_W-1:0]     W, J;
  logic [COST_W-1:0]    Cost;
  logic [MINCOST_W-1:0] jam_mincost;
  logic [MATCH_W-1:0]   jam_matchcount;
  logic                 jam_valid;
  logic                 out_valid;
  logic                 out_ready;
  logic [MINCOST_W-1:0] out_mincost;
  logic [MATCH_W-1:0]   out_matchcount;
  logic [RUNCNT_W-1:0]  out_cycles;
`ifdef JAM_COST_CHECKSUM_EN
  logic [COST_W+5:0]    out_checksum;
`endif

  jam_cost_server #(.COST_W(COST_W), .RUNCNT_W(RUNCNT_W)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .jam_rst        (jam_rst),
    .W              (W),
    .J              (J),
    .Cost           (Cost),
    .jam_mincost    (jam_mincost),
    .jam_matchcount (jam_matchcount),
    .jam_valid      (jam_valid),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_mincost    (out_mincost),
    .out_matchcount (out_matchcount),
`ifdef JAM_COST_CHECKSUM_EN
    .out_checksum   (out_checksum),
`endif
    .out_cycles     (out_cycles)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [MINCOST_W-1:0] mincost;
    logic [MATCH_W-1:0]   match;
    logic [RUNCNT_W-1:0]  cycles;
  } result_t;

  result_t exp_q[$];
  int      n_checks = 0;
  int      n_errors = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Matrix patterns used by the directed loads.
  function automatic logic [COST_W-1:0] cval(input int mode, input int k);
    case (mode)
      0:       return COST_W'(k % 100);
      1:       return ((k / 8) == (k % 8)) ? COST_W'(1) : COST_W'(20);
      2:       return COST_W'((k * 3 + 5) % 128);
      default: return COST_W'((k + 90) % 128);
    endcase
  endfunction

  // Push count beats; gap idle cycles are inserted between beats.
  task automatic load_beats(input int count, input int gap, input int mode);
    for (int k = 0; k < count; k++) begin
      if (k > 0) begin
        in_valid = 1'b0;
        repeat (gap) tick();
      end
      in_valid = 1'b1;
      in_data  = cval(mode, k);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_load(input string name);
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    check(name, in_ready, 1);
  endtask

  // Scoreboard monitor: compare each delivered result with the oldest expected.
  always @(negedge CLK) begin
    result_t e;
    if (!RST && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_result: got mincost %0d, expected no result", out_mincost);
      end else begin
        e = exp_q.pop_front();
        check("result_mincost", out_mincost, e.mincost);
        check("result_matchcount", out_matchcount, e.match);
        check("result_cycles", out_cycles, e.cycles);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int run_n;
    RST = 1'b1; in_valid = 1'b0; in_data = '0; W = '0; J = '0;
    jam_mincost = '0; jam_matchcount = '0; jam_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    RST = 1'b0;
    tick();

    // Reset state and indefinite idle hold.
    check("rst_in_ready", in_ready, 1);
    check("rst_jam_rst", jam_rst, 1);
    check("rst_cost", Cost, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_cycles", out_cycles, 0);
    check("rst_out_mincost", out_mincost, 0);
    repeat (20) tick();
    check("idle_in_ready", in_ready, 1);
    check("idle_jam_rst", jam_rst, 1);
    check("idle_out_valid", out_valid, 0);

    // Gapped load k%100 while a stray Valid is held high (must be ignored).
    jam_valid = 1'b1; jam_mincost = 10'd999; jam_matchcount = 4'd15;
    out_ready = 1'b0;
    load_beats(64, 1, 0);
    jam_valid = 1'b0;
    check("arm_in_ready", in_ready, 0);
    check("arm_jam_rst", jam_rst, 1);
    check("arm_no_capture", out_mincost, 0);
    W = 3'd5; J = 3'd3;
    tick();
    run_n = 0;
    check("run_jam_rst_fall", jam_rst, 0);
    check("cost_5_3", Cost, 43);
    // Lookups in RUN; a beat offered here must not be written.
    W = 3'd0; J = 3'd0; in_valid = 1'b1; in_data = 7'd77;
    tick(); run_n++;
    check("cost_0_0", Cost, 0);
    W = 3'd7; J = 3'd7;
    tick(); run_n++;
    check("cost_7_7", Cost, 63);
    in_valid = 1'b0; W = 3'd2; J = 3'd5;
    tick(); run_n++;
    check("cost_2_5", Cost, 21);
    check("run_in_ready", in_ready, 0);

    // Valid held 5 cycles: only the first cycle's values are captured.
    jam_valid = 1'b1; jam_mincost = 10'd123; jam_matchcount = 4'd5;
    exp_q.push_back('{mincost: 10'd123, match: 4'd5, cycles: RUNCNT_W'(run_n)});
    tick();
    jam_mincost = 10'd456; jam_matchcount = 4'd7;
    repeat (4) tick();
    jam_valid = 1'b0;
`ifdef JAM_COST_CHECKSUM_EN
    check("checksum_ramp", out_checksum, 2016);
`endif
    check("report_jam_rst", jam_rst, 1);
    // Back-pressure: output held stable for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_out_mincost", out_mincost, 123);
      check("bp_out_matchcount", out_matchcount, 5);
      check("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("release_in_ready", in_ready, 1);
    check("release_jam_rst", jam_rst, 1);
    check("release_out_valid", out_valid, 0);
    check("release_hold_mincost", out_mincost, 123);

    // Diagonal matrix run: stub JAM scans the diagonal then reports 8 / 1.
    load_beats(64, 0, 1);
    tick();
    run_n = 0;
    for (int w = 0; w < 8; w++) begin
      W = IDX_W'(w); J = IDX_W'(w);
      tick(); run_n++;
      check("diag_cost", Cost, 1);
    end
    W = 3'd0; J = 3'd1;
    tick(); run_n++;
    check("offdiag_cost", Cost, 20);
    jam_valid = 1'b1; jam_mincost = 10'd8; jam_matchcount = 4'd1;
    exp_q.push_back('{mincost: 10'd8, match: 4'd1, cycles: RUNCNT_W'(run_n)});
    tick();
    jam_valid = 1'b0;
    check("diag_out_valid", out_valid, 1);
`ifdef JAM_COST_CHECKSUM_EN
    check("checksum_diag", out_checksum, 1128);
`endif
    wait_load("diag_back_to_load");

    // Reset in mid-load after 30 beats.
    W = 3'd0; J = 3'd0;
    load_beats(30, 0, 3);
    check("midload_cost_pre", Cost, 90);
    RST = 1'b1;
    #1;
    check("midload_rst_cost", Cost, 0);
    check("midload_rst_in_ready", in_ready, 1);
    check("midload_rst_jam_rst", jam_rst, 1);
    check("midload_rst_out_valid", out_valid, 0);
    check("midload_rst_out_mincost", out_mincost, 0);
    check("midload_rst_out_matchcount", out_matchcount, 0);
    check("midload_rst_out_cycles", out_cycles, 0);
    tick();
    RST = 1'b0;
    tick();

    // Fresh full load: entry 0 must be the new first beat.
    load_beats(64, 0, 2);
    tick();
    check("reload_cost_0_0", Cost, 5);
    check("reload_jam_rst", jam_rst, 0);
    W = 3'd7; J = 3'd7;
    tick();
    check("reload_cost_7_7", Cost, 66);

    // Reset in mid-run: jam_rst must rise without a clock edge.
    RST = 1'b1;
    #1;
    check("midrun_rst_jam_rst", jam_rst, 1);
    check("midrun_rst_cost", Cost, 0);
    check("midrun_rst_in_ready", in_ready, 1);
    tick();
    RST = 1'b0;
    tick();

    // Load after mid-run reset; Valid on the very first RUN cycle.
    W = 3'd0; J = 3'd0;
    load_beats(64, 0, 1);
    tick();
    check("post_rst_cost_0_0", Cost, 1);
    jam_valid = 1'b1; jam_mincost = 10'd77; jam_matchcount = 4'd3;
    exp_q.push_back('{mincost: 10'd77, match: 4'd3, cycles: RUNCNT_W'(0)});
    tick();
    jam_valid = 1'b0;
    wait_load("first_cycle_back_to_load");

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/jam_cost_server.md
Name: jam_cost_server

Overview:
Upstream feeder for the JAM job-assignment solver. It accepts an 8x8 cost matrix from the host over a valid/ready stream and holds JAM in reset until the matrix is complete. It then serves JAM's W/J lookups with registered Cost data. When JAM raises Valid, it captures MinCost/MatchCount and presents them on a result handshake before re-arming for the next matrix.

Parameters:
COST_W, 7, cost entry width (must match JAM Cost port)
RUNCNT_W, 20, width of the saturating run-cycle counter

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
in_valid  in  1  host cost beat valid
in_ready  out  1  server accepts cost beat
in_data  in  COST_W  cost beat, row-major: beat k is cost[k/8][k%8]
jam_rst  out  1  reset to JAM, active-high
W  in  3  worker index from JAM
J  in  3  job index from JAM
Cost  out  COST_W  cost[W][J] to JAM, registered
jam_mincost  in  10  JAM MinCost
jam_matchcount  in  4  JAM MatchCount
jam_valid  in  1  JAM Valid
out_valid  out  1  result valid
out_ready  in  1  host accepts result
out_mincost  out  10  captured MinCost
out_matchcount  out  4  captured MatchCount
out_cycles  out  RUNCNT_W  cycles spent in RUN, saturating

Behaviour:
- Reset: state LOAD, wr_ptr=0, all 64 entries=0, Cost=0, jam_rst=1, out_valid=0, out_mincost=0, out_matchcount=0, out_cycles=0, run counter=0.
- States: LOAD -> ARM -> RUN -> REPORT -> LOAD.
- in_ready = (state==LOAD); combinational from state only, with no dependency on in_valid.
- LOAD:
  - On in_valid&&in_ready, write in_data to entry {row=wr_ptr[5:3], col=wr_ptr[2:0]} and increment the 6-bit wr_ptr.
  - The accepted beat at wr_ptr==63 moves to ARM and wraps wr_ptr to 0.
  - in_valid low leaves the state unchanged, with no timeout.
- ARM: exactly one cycle, jam_rst still 1, run counter cleared to 0. Next cycle goes to RUN.
- jam_rst is registered: 1 in LOAD/ARM/REPORT, 0 in RUN. It deasserts on the clock edge that enters RUN.
- Cost is registered every cycle in every state from entry[W][J], giving 1-cycle latency. JAM holds W/J stable across its IDLE and RECV cycles, so the data is correct when RECV samples it.
- RUN:
  - Run counter increments each cycle and saturates at all-ones.
  - The first cycle with jam_valid=1 captures jam_mincost and jam_matchcount into out_mincost/out_matchcount, and the counter into out_cycles. The state then moves to REPORT.
- REPORT:
  - out_valid=1, output data held stable.
  - On out_valid&&out_ready: out_valid goes to 0 next cycle, state goes to LOAD, wr_ptr=0.
  - Output registers keep their last values until the next capture.
- jam_valid is ignored outside RUN. in_valid is ignored outside LOAD, with no write and no pointer movement.
- The matrix may be rewritten only in LOAD. Entries not overwritten in a new LOAD are impossible, since LOAD always takes 64 beats.
- RST mid-operation in any state: immediate return to reset values, including clearing the matrix. jam_rst=1 asynchronously with RST.

Optional Feature:
- Macro: JAM_COST_CHECKSUM_EN.
- Defined:
  - Adds output port out_checksum (COST_W+6 bits), a sum of all 64 accepted beats.
  - Cleared on the first beat of LOAD; final value is valid with out_valid.
  - Reset value 0.
- Undefined: port and adder absent; all other behaviour identical.

Decomposition:
- Shared package jam_pkg:
  - constants IDX_W=3, ENTRIES=64, MINCOST_W=10, MATCH_W=4, default COST_W
  - state enum {LOAD, ARM, RUN, REPORT}
- One sub-module, jam_cost_ram: 64 x COST_W register array with one write port (6-bit addr, we), one registered read port (6-bit addr {W,J}), and asynchronous reset to 0.

Test Plan:
- Reset then idle: in_ready=1, jam_rst=1, Cost=0, out_valid=0; holds indefinitely with in_valid=0.
- Load with in_valid toggled every other cycle, beats k=0..63 with value k%100. Then W=5,J=3 -> Cost=43 one cycle later. jam_rst falls exactly 2 cycles after the 64th accept, and in_ready=0 thereafter.
- Full system with the JAM instance, cost[w][j]=(w==j)?1:20 -> out_mincost=8, out_matchcount=1, out_valid=1. out_cycles equals the number of jam_rst=0 cycles before Valid.
- Back-pressure: hold out_ready=0 for 10 cycles -> out_valid and data stable, in_ready=0. Raise out_ready -> LOAD next cycle, in_ready=1, jam_rst=1.
- Stub JAM with jam_valid=1 during LOAD and REPORT -> no capture. In RUN, jam_valid held high for 5 cycles -> single capture of first-cycle values.
- RST asserted mid-LOAD at beat 30 and again mid-RUN -> all outputs return to reset values immediately. A subsequent full load gives correct Cost for entry 0 (first beat), not stale data.
